// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer feeding the rasterizer-to-framebuffer-writer FIFO, one pixel per cycle.
// Optional screen clipping is enabled by defining LINE_RASTERIZER_CLIP_EN.
module line_rasterizer #(
  parameter int X_W               = 11,
  parameter int Y_W               = 10,
  parameter int LINE_LEN          = 9,
  parameter int COL_LEN           = 10,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int RAST_FBW_FIFO_LEN = 96
) (
  input  logic                         PLB_clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_flush,
  input  logic [X_W-1:0]               cmd_x0,
  input  logic [X_W-1:0]               cmd_x1,
  input  logic [Y_W-1:0]               cmd_y0,
  input  logic [Y_W-1:0]               cmd_y1,
  input  logic [31:0]                  cmd_color,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [0:RAST_FBW_FIFO_LEN-1] fifo_data,
  output logic                         busy,
  output logic [31:0]                  pix_count
);

  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;

  // Visible area must fit the word fields and the word layout is fixed at 96 bits.
  if (SCREEN_W > (1 << COL_LEN) || SCREEN_H > (1 << LINE_LEN) || RAST_FBW_FIFO_LEN != 96)
  begin : g_bad_cfg
    $error("line_rasterizer: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, FLUSH} state_t;

  state_t                state;
  logic [X_W-1:0]        x0_q, x1_q, x_q;
  logic [Y_W-1:0]        y0_q, y1_q, y_q;
  logic [31:0]           color_q;
  logic signed [CW-1:0]  dx_q, dy_q, err_q;
  logic                  sx_neg, sy_neg;

  logic signed [CW-1:0]  dx_raw, dy_raw, dx_abs, dy_neg, err_next;
  logic signed [CW:0]    e2;
  logic                  step_x, step_y, at_end, visible, pix_wr, advance;

  assign dx_raw = $signed(CW'(x1_q)) - $signed(CW'(x0_q));
  assign dy_raw = $signed(CW'(y1_q)) - $signed(CW'(y0_q));
  assign dx_abs = dx_raw[CW-1] ? -dx_raw : dx_raw;
  assign dy_neg = dy_raw[CW-1] ? dy_raw : -dy_raw;

  // Both error tests look at the pre-update err; both corrections may land together.
  assign e2       = {err_q, 1'b0};
  assign step_x   = (e2 >= dy_q);
  assign step_y   = (e2 <= dx_q);
  assign err_next = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
  assign at_end   = (x_q == x1_q) && (y_q == y1_q);

`ifdef LINE_RASTERIZER_CLIP_EN
  assign visible = (x_q < X_W'(SCREEN_W)) && (y_q < Y_W'(SCREEN_H));
`else
  assign visible = 1'b1;
`endif

  // Off-screen pixels are skipped without waiting for FIFO space.
  assign pix_wr  = (state == DRAW) && visible && !fifo_full;
  assign advance = (state == DRAW) && (pix_wr || !visible);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      pix_count <= '0;
    end else begin
      if (pix_wr) pix_count <= pix_count + 32'd1;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_flush) begin
              state <= FLUSH;
            end else begin
              x0_q    <= cmd_x0;
              x1_q    <= cmd_x1;
              y0_q    <= cmd_y0;
              y1_q    <= cmd_y1;
              color_q <= cmd_color;
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          dx_q   <= dx_abs;
          dy_q   <= dy_neg;
          err_q  <= dx_abs + dy_neg;
          sx_neg <= (x0_q >= x1_q);
          sy_neg <= (y0_q >= y1_q);
          x_q    <= x0_q;
          y_q    <= y0_q;
          state  <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (at_end) begin
              state <= IDLE;
            end else begin
              err_q <= err_next;
              if (step_x) x_q <= sx_neg ? x_q - 1'b1 : x_q + 1'b1;
              if (step_y) y_q <= sy_neg ? y_q - 1'b1 : y_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!fifo_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    cmd_ready  = (state == IDLE);
    busy       = (state != IDLE);
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    case (state)
      DRAW: begin
        fifo_wr_en = pix_wr;
        fifo_data  = {16'(y_q[LINE_LEN-1:0]), 16'(x_q[COL_LEN-1:0]), color_q, 32'h0};
      end
      FLUSH: begin
        fifo_wr_en = !fifo_full;
        fifo_data  = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: directed vector table, corner sequences, random lines vs a model.
module tb_line_rasterizer;

  logic        PLB_clk   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_flush = 1'b0;
  logic [10:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [9:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [31:0] cmd_color = '0;
  logic        fifo_full = 1'b0;
  logic        cmd_ready, fifo_wr_en, busy;
  logic [0:95] fifo_data;
  logic [31:0] pix_count;

  line_rasterizer dut (
    .PLB_clk(PLB_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_flush(cmd_flush), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .busy(busy), .pix_count(pix_count)
  );

  always #5 PLB_clk = ~PLB_clk;

  int cyc = 0;
  always @(posedge PLB_clk) cyc <= cyc + 1;

  // Every FIFO write, with the cycle it happened in.
  logic [0:95] cap_q[$];
  int          cap_cyc[$];
  always @(negedge PLB_clk)
    if (reset_n && fifo_wr_en) begin
      cap_q.push_back(fifo_data);
      cap_cyc.push_back(cyc);
    end

  logic [0:95] exp_q[$];
  int exp_pix = 0;
  int passed = 0, total = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [0:95] pix_word(input int x, input int y, input logic [31:0] c);
    logic [15:0] l, k;
    l = 16'(y & 511);
    k = 16'(x & 1023);
    return {l, k, c, 32'h0};
  endfunction

  function automatic bit on_screen(input int x, input int y);
`ifdef LINE_RASTERIZER_CLIP_EN
    return (x < 640) && (y < 480);
`else
    return 1'b1;
`endif
  endfunction

  // Reference walk in plain integer arithmetic; appends the expected words.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1, input logic [31:0] c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int k = 0; k < 5000; k++) begin
      if (on_screen(x, y)) begin
        exp_q.push_back(pix_word(x, y, c));
        exp_pix++;
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic send_cmd(input bit fl, input int x0, input int y0, input int x1, input int y1,
                          input logic [31:0] c, output int acc);
    int n;
    @(posedge PLB_clk); #1;
    cmd_valid = 1'b1;
    cmd_flush = fl;
    cmd_x0 = 11'(x0); cmd_y0 = 10'(y0);
    cmd_x1 = 11'(x1); cmd_y1 = 10'(y1);
    cmd_color = c;
    n = 0;
    @(negedge PLB_clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge PLB_clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(posedge PLB_clk); #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(input bit rnd, output int idle_cyc);
    int n;
    n = 0;
    do begin
      @(posedge PLB_clk); #1;
      fifo_full = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      n++;
    end while (busy && n < 3000);
    if (busy) check("idle_timeout", 0, 1);
    fifo_full = 1'b0;
    idle_cyc = cyc;
  endtask

  task automatic compare_from(input int base, input string tag);
    check({tag, " count"}, 96'(cap_q.size() - base), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++)
      check($sformatf("%s word%0d", tag, i), cap_q[base + i], exp_q[i]);
    check({tag, " pix_count"}, pix_count, 32'(exp_pix));
  endtask

  typedef struct {
    int          x0, y0, x1, y1;
    logic [31:0] color;
    int          exp_n;
    int          last_x, last_y;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base, acc, acc2, idle_c, lastw, sz_rst, x0, y0, x1, y1;
    logic [0:95] w;
    logic [0:95] steep[4];

    vecs[0] = '{0, 0, 3, 0, 32'h00FF00FF, 4, 3, 0};
    vecs[1] = '{5, 9, 4, 6, 32'h12345678, 4, 4, 6};
    vecs[2] = '{0, 0, 2, 2, 32'hCAFEF00D, 3, 2, 2};
    vecs[3] = '{10, 20, 10, 20, 32'h0BADBEEF, 1, 10, 20};
    vecs[4] = '{0, 5, 1, 5, 32'h11112222, 2, 1, 5};
    vecs[6] = '{0, 0, 7, 3, 32'hA5A5A5A5, 8, 7, 3};
`ifdef LINE_RASTERIZER_CLIP_EN
    vecs[5] = '{638, 0, 641, 0, 32'h55AA55AA, 2, 639, 0};
    vecs[7] = '{700, 0, 700, 3, 32'h01010101, 0, 0, 0};
`else
    vecs[5] = '{638, 0, 641, 0, 32'h55AA55AA, 4, 641, 0};
    vecs[7] = '{700, 0, 700, 3, 32'h01010101, 4, 700, 3};
`endif

    // Reset state.
    repeat (3) @(posedge PLB_clk);
    @(negedge PLB_clk);
    reset_n = 1'b1;
    #1;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset wr_en", fifo_wr_en, 0);
    check("reset data", fifo_data, 0);
    check("reset pix_count", pix_count, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      exp_q.delete();
      model_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color);
      base = cap_q.size();
      send_cmd(0, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color, acc);
      wait_idle(0, idle_c);
      check($sformatf("vec%0d n", i), 96'(cap_q.size() - base), 96'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0 && cap_q.size() > base) begin
        w = cap_q[cap_q.size() - 1];
        check($sformatf("vec%0d last col", i), w[16:31], 16'(vecs[i].last_x));
        check($sformatf("vec%0d last line", i), w[0:15], 16'(vecs[i].last_y));
      end
      compare_from(base, $sformatf("vec%0d", i));
    end

    // Horizontal line: exact words, back-to-back cycles, 1+1+N latency.
    base = cap_q.size();
    send_cmd(0, 0, 0, 3, 0, 32'h00FF00FF, acc);
    wait_idle(0, idle_c);
    exp_pix += 4;
    check("horiz n", 96'(cap_q.size() - base), 4);
    if (cap_q.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("horiz word%0d", i), cap_q[base + i], {16'h0, 16'(i), 32'h00FF00FF, 32'h0});
        check($sformatf("horiz cyc%0d", i), 96'(cap_cyc[base + i]), 96'(acc + 1 + i));
      end
      check("horiz idle cycle", 96'(idle_c), 96'(cap_cyc[base + 3] + 1));
    end
    check("horiz pix_count", pix_count, 32'(exp_pix));

    // Steep reverse line: hand-derived walk and busy drop.
    steep[0] = {16'd9, 16'd5, 32'hDEADBEEF, 32'h0};
    steep[1] = {16'd8, 16'd5, 32'hDEADBEEF, 32'h0};
    steep[2] = {16'd7, 16'd4, 32'hDEADBEEF, 32'h0};
    steep[3] = {16'd6, 16'd4, 32'hDEADBEEF, 32'h0};
    base = cap_q.size();
    send_cmd(0, 5, 9, 4, 6, 32'hDEADBEEF, acc);
    wait_idle(0, idle_c);
    exp_pix += 4;
    check("steep n", 96'(cap_q.size() - base), 4);
    if (cap_q.size() - base == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("steep word%0d", i), cap_q[base + i], steep[i]);
      check("steep busy drop", 96'(idle_c), 96'(cap_cyc[base + 3] + 1));
    end

    // Diagonal with a 3-cycle stall right after the first write.
    exp_q.delete();
    model_line(0, 0, 2, 2, 32'h77777777);
    base = cap_q.size();
    send_cmd(0, 0, 0, 2, 2, 32'h77777777, acc);
    for (int n = 0; n < 50 && cap_q.size() - base < 1; n++) begin
      @(negedge PLB_clk); #1;
    end
    @(posedge PLB_clk); #1;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PLB_clk);
      check($sformatf("stall%0d wr_en", i), fifo_wr_en, 0);
      check($sformatf("stall%0d held pixel", i), fifo_data, pix_word(1, 1, 32'h77777777));
      @(posedge PLB_clk);
    end
    #1;
    fifo_full = 1'b0;
    wait_idle(0, idle_c);
    compare_from(base, "stall");

    // Line followed by a flush: flush word strictly after the pixels.
    exp_q.delete();
    model_line(0, 5, 1, 5, 32'h0F0F0F0F);
    exp_q.push_back('1);
    base = cap_q.size();
    send_cmd(0, 0, 5, 1, 5, 32'h0F0F0F0F, acc);
    send_cmd(1, 0, 0, 0, 0, 32'h0, acc2);
    wait_idle(0, idle_c);
    compare_from(base, "flush");

    // Asynchronous reset mid-line.
    base = cap_q.size();
    send_cmd(0, 0, 0, 100, 0, 32'h33333333, acc);
    for (int n = 0; n < 300 && cap_q.size() - base < 10; n++) begin
      @(negedge PLB_clk); #1;
    end
    check("midline reached 10", 96'(cap_q.size() - base >= 10), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst wr_en", fifo_wr_en, 0);
    check("rst busy", busy, 0);
    check("rst pix_count", pix_count, 0);
    exp_pix = 0;
    sz_rst = cap_q.size();
    repeat (2) @(posedge PLB_clk);
    @(negedge PLB_clk);
    reset_n = 1'b1;
    #1;
    check("post-rst cmd_ready", cmd_ready, 1);
    check("post-rst busy", busy, 0);
    check("post-rst data", fifo_data, 0);
    repeat (3) @(posedge PLB_clk);
    #1;
    check("post-rst no writes", 96'(cap_q.size()), 96'(sz_rst));
    exp_q.delete();
    model_line(2, 3, 6, 5, 32'h44444444);
    base = cap_q.size();
    send_cmd(0, 2, 3, 6, 5, 32'h44444444, acc);
    wait_idle(0, idle_c);
    compare_from(base, "post-rst line");

    // Random lines and flushes with random back-pressure.
    for (int it = 0; it < 30; it++) begin
      exp_q.delete();
      base = cap_q.size();
      if ($urandom_range(0, 5) == 0) begin
        exp_q.push_back('1);
        send_cmd(1, 0, 0, 0, 0, 32'h0, acc);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          x0 = $urandom_range(620, 660);
          y0 = $urandom_range(465, 495);
        end else begin
          x0 = $urandom_range(0, 2047);
          y0 = $urandom_range(0, 1023);
        end
        x1 = x0 + int'($urandom_range(0, 24)) - 12;
        y1 = y0 + int'($urandom_range(0, 24)) - 12;
        x1 = (x1 < 0) ? 0 : (x1 > 2047) ? 2047 : x1;
        y1 = (y1 < 0) ? 0 : (y1 > 1023) ? 1023 : y1;
        w[0:31] = $urandom;
        model_line(x0, y0, x1, y1, w[0:31]);
        send_cmd(0, x0, y0, x1, y1, w[0:31], acc);
      end
      wait_idle(1, idle_c);
      compare_from(base, $sformatf("rand%0d", it));
    end

    lastw = total;
    $display("%0d/%0d checks passed", passed, lastw);
    $finish;
  end

endmodule
